// File: rtl/procyon_lib_pkg.sv
// Shared Wishbone encodings for the procyon bus blocks.
package procyon_lib_pkg;

  // Cycle type identifier.
  typedef enum logic [2:0] {
    WB_CTI_CLASSIC = 3'b000,
    WB_CTI_CONST   = 3'b001,
    WB_CTI_INCR    = 3'b010,
    WB_CTI_EOB     = 3'b111
  } wb_cti_e;

  // Burst type extension.
  typedef enum logic [1:0] {
    WB_BTE_LINEAR = 2'b00,
    WB_BTE_WRAP4  = 2'b01,
    WB_BTE_WRAP8  = 2'b10,
    WB_BTE_WRAP16 = 2'b11
  } wb_bte_e;

  // Slave-side accept state machine encoding.
  typedef enum logic [2:0] {
    WB_ACCEPT_IDLE     = 3'd0,
    WB_ACCEPT_RD_FIRST = 3'd1,
    WB_ACCEPT_RD_BURST = 3'd2,
    WB_ACCEPT_WR_BURST = 3'd3,
    WB_ACCEPT_DONE     = 3'd4
  } wb_accept_e;

  // True when the CTI code continues an incrementing burst.
  function automatic logic wb_cti_is_incr(input logic [2:0] cti);
    return cti == WB_CTI_INCR;
  endfunction

endpackage

// File: rtl/procyon_wb_burst_addr_gen.sv
// Next word address of an incrementing burst, wrapping the low bits per BTE.
module procyon_wb_burst_addr_gen
  import procyon_lib_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_bte,
  output logic [ADDR_WIDTH-1:0] o_next_addr_c
);

  logic [ADDR_WIDTH-1:0] inc_c;
  logic [ADDR_WIDTH-1:0] wrap_mask_c;

  // Only the masked low bits take the incremented value; the rest hold.
  always_comb begin
    inc_c = i_addr + ADDR_WIDTH'(1);
    case (wb_bte_e'(i_bte))
      WB_BTE_WRAP4:  wrap_mask_c = ADDR_WIDTH'(3);
      WB_BTE_WRAP8:  wrap_mask_c = ADDR_WIDTH'(7);
      WB_BTE_WRAP16: wrap_mask_c = ADDR_WIDTH'(15);
      default:       wrap_mask_c = '1;
    endcase
    o_next_addr_c = (i_addr & ~wrap_mask_c) | (inc_c & wrap_mask_c);
  end

endmodule

// File: rtl/procyon_wb_sram_responder.sv
// Wishbone B4 registered-feedback responder in front of a 1-cycle-latency SRAM.
module procyon_wb_sram_responder
  import procyon_lib_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH  = 16,
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 16
) (
  input  logic                         i_wb_clk,
  input  logic                         i_wb_rst,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  input  logic                         i_wb_we,
  input  logic [2:0]                   i_wb_cti,
  input  logic [1:0]                   i_wb_bte,
  input  logic [WB_ADDR_WIDTH-1:0]     i_wb_adr,
  input  logic [WB_DATA_WIDTH-1:0]     i_wb_dat,
  input  logic [WB_DATA_WIDTH/8-1:0]   i_wb_sel,
  output logic [WB_DATA_WIDTH-1:0]     o_wb_dat,
  output logic                         o_wb_ack,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]    o_mem_addr,
  output logic [WB_DATA_WIDTH-1:0]     o_mem_wdata,
  output logic [WB_DATA_WIDTH/8-1:0]   o_mem_be,
  input  logic [WB_DATA_WIDTH-1:0]     i_mem_rdata
);

  localparam int unsigned DW       = WB_DATA_WIDTH;
  localparam int unsigned AW       = MEM_ADDR_WIDTH;
  localparam int unsigned SW       = WB_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(SW);

  wb_accept_e    state_q, state_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          skid_vld_q, skid_vld_d;
  logic          rd_pend_q, rd_pend_d;
  logic          burst_q, burst_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [SW-1:0] wr_be_q, wr_be_d;

  logic          rd_issue_c;
  logic [AW-1:0] rd_addr_c;
  logic [AW-1:0] adr_word_c;
  logic [AW-1:0] gen_in_c;
  logic [AW-1:0] gen_next_c;
  logic          xfer_c;
  logic          out_free_c;
  logic          unused_adr_c;

  assign adr_word_c   = i_wb_adr[ADDR_LSB +: AW];
  assign unused_adr_c = ^i_wb_adr;
  assign xfer_c       = i_wb_cyc & i_wb_stb & ack_q;
  assign gen_in_c     = (state_q == WB_ACCEPT_IDLE) ? adr_word_c : ptr_q;

  // One shared incrementer: start address in IDLE, burst pointer otherwise.
  procyon_wb_burst_addr_gen #(
    .ADDR_WIDTH (AW)
  ) u_addr_gen (
    .i_addr        (gen_in_c),
    .i_bte         (i_wb_bte),
    .o_next_addr_c (gen_next_c)
  );

  // Next-state, read pipeline (output stage + skid) and write-commit capture.
  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    dat_d      = dat_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    rd_pend_d  = 1'b0;
    burst_d    = burst_q;
    ptr_d      = ptr_q;
    wr_pend_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_be_d    = wr_be_q;
    rd_issue_c = 1'b0;
    rd_addr_c  = ptr_q;
    out_free_c = 1'b0;

    case (state_q)
      WB_ACCEPT_IDLE: begin
        ack_d      = 1'b0;
        skid_vld_d = 1'b0;
        // A leftover write commit owns the SRAM port this cycle, so hold off.
        if (i_wb_cyc && i_wb_stb && !wr_pend_q) begin
          burst_d = wb_cti_is_incr(i_wb_cti);
          if (i_wb_we) begin
            state_d = WB_ACCEPT_WR_BURST;
            ack_d   = 1'b1;
            ptr_d   = adr_word_c;
          end else begin
            state_d    = WB_ACCEPT_RD_FIRST;
            rd_issue_c = 1'b1;
            rd_addr_c  = adr_word_c;
            rd_pend_d  = 1'b1;
            ptr_d      = gen_next_c;
          end
        end
      end

      WB_ACCEPT_RD_FIRST, WB_ACCEPT_RD_BURST: begin
        if (!i_wb_cyc) begin
          state_d    = WB_ACCEPT_IDLE;
          ack_d      = 1'b0;
          skid_vld_d = 1'b0;
        end else if (xfer_c && (!burst_q || !wb_cti_is_incr(i_wb_cti))) begin
          // Last beat taken: prefetched and in-flight data are dropped.
          state_d    = burst_q ? WB_ACCEPT_IDLE : WB_ACCEPT_DONE;
          ack_d      = 1'b0;
          skid_vld_d = 1'b0;
        end else begin
          if (burst_q) begin
            state_d = WB_ACCEPT_RD_BURST;
          end
          out_free_c = !ack_q || xfer_c;
          if (out_free_c) begin
            if (skid_vld_q) begin
              dat_d      = skid_q;
              ack_d      = 1'b1;
              skid_vld_d = rd_pend_q;
              if (rd_pend_q) begin
                skid_d = i_mem_rdata;
              end
            end else if (rd_pend_q) begin
              dat_d = i_mem_rdata;
              ack_d = 1'b1;
            end else begin
              ack_d = 1'b0;
            end
          end else if (rd_pend_q) begin
            skid_d     = i_mem_rdata;
            skid_vld_d = 1'b1;
          end
          // Prefetch only when the returning word is guaranteed a free slot.
          if (burst_q && !skid_vld_d) begin
            rd_issue_c = 1'b1;
            rd_addr_c  = ptr_q;
            rd_pend_d  = 1'b1;
            ptr_d      = gen_next_c;
          end
        end
      end

      WB_ACCEPT_WR_BURST: begin
        if (!i_wb_cyc) begin
          state_d = WB_ACCEPT_IDLE;
          ack_d   = 1'b0;
        end else if (xfer_c) begin
          wr_pend_d = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = i_wb_dat;
          wr_be_d   = i_wb_sel;
          ptr_d     = gen_next_c;
          if (!burst_q) begin
            state_d = WB_ACCEPT_DONE;
            ack_d   = 1'b0;
          end else if (!wb_cti_is_incr(i_wb_cti)) begin
            state_d = WB_ACCEPT_IDLE;
            ack_d   = 1'b0;
          end else begin
            ack_d = 1'b1;
          end
        end
      end

      WB_ACCEPT_DONE: begin
        state_d    = WB_ACCEPT_IDLE;
        ack_d      = 1'b0;
        skid_vld_d = 1'b0;
      end

      default: begin
        state_d    = WB_ACCEPT_IDLE;
        ack_d      = 1'b0;
        skid_vld_d = 1'b0;
      end
    endcase
  end

  // SRAM port: write commits and read issues never coincide; reset blanks it.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    if (!i_wb_rst) begin
      if (wr_pend_q) begin
        o_mem_en    = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = wr_addr_q;
        o_mem_wdata = wr_data_q;
        o_mem_be    = wr_be_q;
      end else if (rd_issue_c) begin
        o_mem_en   = 1'b1;
        o_mem_addr = rd_addr_c;
      end
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q    <= WB_ACCEPT_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      burst_q    <= 1'b0;
      ptr_q      <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rd_pend_q  <= rd_pend_d;
      burst_q    <= burst_d;
      ptr_q      <= ptr_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_dat = dat_q;

endmodule

// File: doc/procyon_wb_sram_responder.md
Name: procyon_wb_sram_responder

Overview:
- Wishbone B4 registered-feedback responder that services classic and incrementing-burst cycles from the BIU-side Wishbone master.
- Sits between the Wishbone bus and a synchronous single-port SRAM with 1-cycle read latency.
- Decodes CTI/BTE, generates burst addresses with wrap, and drives registered ACK/DAT back to the master.

Parameters:
- WB_DATA_WIDTH, 16, Wishbone data width in bits (power of 2, >= 8).
- WB_ADDR_WIDTH, 32, Wishbone byte-address width.
- MEM_ADDR_WIDTH, 16, SRAM word-address width; SRAM depth = 2^MEM_ADDR_WIDTH words.

Ports:
- i_wb_clk  in  1  clock; all logic on rising edge.
- i_wb_rst  in  1  synchronous, active-high reset.
- i_wb_cyc  in  1  bus cycle active.
- i_wb_stb  in  1  strobe; beat valid.
- i_wb_we  in  1  1=write, 0=read.
- i_wb_cti  in  3  cycle type identifier.
- i_wb_bte  in  2  burst type extension.
- i_wb_adr  in  WB_ADDR_WIDTH  byte address.
- i_wb_dat  in  WB_DATA_WIDTH  write data.
- i_wb_sel  in  WB_DATA_WIDTH/8  byte selects.
- o_wb_dat  out  WB_DATA_WIDTH  read data (registered).
- o_wb_ack  out  1  acknowledge (registered).
- o_mem_en  out  1  SRAM access enable.
- o_mem_we  out  1  SRAM write enable.
- o_mem_addr  out  MEM_ADDR_WIDTH  SRAM word address.
- o_mem_wdata  out  WB_DATA_WIDTH  SRAM write data.
- o_mem_be  out  WB_DATA_WIDTH/8  SRAM byte enables.
- i_mem_rdata  in  WB_DATA_WIDTH  SRAM read data; valid the cycle after o_mem_en & !o_mem_we.

Behaviour:
- Reset: all outputs 0; state IDLE; skid buffer empty. A reset mid-burst aborts with no ack and no further SRAM access.
- Beat transfer: a beat completes only in a cycle with i_wb_cyc & i_wb_stb & o_wb_ack.
- Ack in a stb-low cycle transfers nothing; ack and data hold until stb returns.
- Word address: i_wb_adr[log2(WB_DATA_WIDTH/8) +: MEM_ADDR_WIDTH]. Upper bits are ignored.
- CTI 000, 001 or 111 at cycle start: classic cycle.
  - Classic read: accept at t0, SRAM read at t0, ack + data at t2.
  - Classic write: ack at t1, SRAM write at t2 with sel -> be.
  - One ack per cycle; return to IDLE after the transfer.
- CTI 010: incrementing burst.
  - Next address = addr+1, with low bits wrapped per BTE: LINEAR full-width wrap; 4BEAT [1:0]; 8BEAT [2:0]; 16BEAT [3:0].
  - Read burst: first ack at t2, then one ack per cycle while stb is held.
  - Read prefetch: at most 1 outstanding SRAM read plus a 1-entry skid register. No data is lost on stb stalls, and no new read is issued while the skid is full.
  - Write burst: ack from t1 onward, held high each cycle. Each completed beat writes the SRAM the following cycle.
  - A beat with CTI 111 is the last beat. After its transfer, return to IDLE, drop ack next cycle, and discard prefetched data.
- i_wb_cyc low at any time: abort. Next cycle ack = 0 and state IDLE. A pending write for an already-completed beat still commits; an uncompleted beat never writes.
- States: IDLE, RD_FIRST, RD_BURST, WR_BURST, DONE.
  - IDLE -> RD_FIRST on cyc&stb&!we.
  - IDLE -> WR_BURST on cyc&stb&we.
  - RD_FIRST -> RD_BURST when CTI=010, otherwise -> DONE after the ack transfer.
  - DONE -> IDLE after 1 cycle. This gives a one-cycle gap between back-to-back classic cycles.
- CTI and BTE are sampled per beat. A BTE change mid-burst takes effect on the next address.

Decomposition:
- procyon_lib_pkg already holds the WB_CTI/WB_BTE defines. Add a WB_ACCEPT state-encoding typedef there if shared.
- One sub-module: procyon_wb_burst_addr_gen (combinational next address from current address + BTE), reused by the future master-side burst generator.

Test Plan:
- Classic write 0x00000010, dat 0xBEEF, sel 11 -> ack at t1 only; SRAM word 8 = 0xBEEF at t2. Classic read of 0x10 -> o_wb_dat 0xBEEF with ack at t2.
- Sel 01 write of 0x1234 to a word holding 0xBEEF -> o_mem_be=01; readback 0xBE34.
- 4BEAT wrap read burst at byte 0x0C (word 6) -> acks for words 6,7,4,5 on consecutive cycles; 4th beat CTI=111; ack low after.
- Read burst with stb dropped 2 cycles after beat 1 -> ack held, no data lost; beats 2..4 return correct data in order; at most 1 SRAM read outstanding.
- Linear write burst of 3 beats 0xA0,0xA1,0xA2 at word 0xFFFF -> SRAM words 0xFFFF,0x0000,0x0001 written.
- cyc dropped mid write burst after 2 beats -> only 2 words written; ack 0 next cycle. Also assert i_wb_rst mid read burst -> outputs 0 next cycle.
